// File: rtl/repl_pkg.sv
// repl_pkg: shared types and helpers for victim allocation / replacement.
//   victim_state_t : miss-handling FSM states
//   inv_sel_t      : {found, way} result of the invalid-way search
//   assoc_legal()  : only 2- and 4-way sets match the PLRU generator
//   first_invalid(): lowest-numbered invalid way
//   onehot()       : way number to one-hot way mask
package repl_pkg;

  localparam int MAX_WAYS  = 4;
  localparam int MAX_WAY_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_CHOOSE,
    ST_WB,
    ST_REFILL,
    ST_UPDATE
  } victim_state_t;

  typedef struct packed {
    logic                 found;
    logic [MAX_WAY_W-1:0] way;
  } inv_sel_t;

  function automatic bit assoc_legal(input int n);
    return (n == 2) || (n == 4);
  endfunction

  // Scan high to low so the last hit written is the lowest invalid way.
  function automatic inv_sel_t first_invalid(input logic [MAX_WAYS-1:0] valid);
    inv_sel_t r;
    r = '0;
    for (int i = MAX_WAYS - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        r.found = 1'b1;
        r.way   = MAX_WAY_W'(i);
      end
    end
    return r;
  endfunction

  function automatic logic [MAX_WAYS-1:0] onehot(input logic [MAX_WAY_W-1:0] way);
    logic [MAX_WAYS-1:0] r;
    r      = '0;
    r[way] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/victim_alloc_ctrl_if.sv
// victim_alloc_ctrl_if: pipeline, tag RAM, PLRU and bus signals of the
// miss-handling controller.
//   master : controller side (drives requests, strobes, completion)
//   slave  : environment side (pipeline, tag RAM, PLRU generator, bus)
interface victim_alloc_ctrl_if #(
  parameter int SET_ASSOC   = 4,
  parameter int INDEX_WIDTH = 7,
  parameter int WAY_WIDTH   = $clog2(SET_ASSOC)
);
  // pipeline
  logic                   miss_req;
  logic [INDEX_WIDTH-1:0] miss_index;
  logic                   miss_ready;
  logic                   done;
  logic [WAY_WIDTH-1:0]   done_way;
  // tag/valid/dirty RAM
  logic                   tag_rd;
  logic [INDEX_WIDTH-1:0] tag_rd_index;
  logic [SET_ASSOC-1:0]   way_valid;
  logic [SET_ASSOC-1:0]   way_dirty;
  // PLRU generator
  logic [INDEX_WIDTH-1:0] plru_index;
  logic [WAY_WIDTH-1:0]   plru_repl_index;
  logic [SET_ASSOC-1:0]   plru_access;
  logic                   plru_update;
  // bus
  logic                   wb_req;
  logic [WAY_WIDTH-1:0]   wb_way;
  logic [INDEX_WIDTH-1:0] wb_index;
  logic                   wb_ack;
  logic                   refill_req;
  logic [WAY_WIDTH-1:0]   refill_way;
  logic [INDEX_WIDTH-1:0] refill_index;
  logic                   refill_done;

  modport master (
    input  miss_req, miss_index, way_valid, way_dirty, plru_repl_index,
           wb_ack, refill_done,
    output miss_ready, done, done_way, tag_rd, tag_rd_index, plru_index,
           plru_access, plru_update, wb_req, wb_way, wb_index,
           refill_req, refill_way, refill_index
  );

  modport slave (
    output miss_req, miss_index, way_valid, way_dirty, plru_repl_index,
           wb_ack, refill_done,
    input  miss_ready, done, done_way, tag_rd, tag_rd_index, plru_index,
           plru_access, plru_update, wb_req, wb_way, wb_index,
           refill_req, refill_way, refill_index
  );
endinterface

// File: rtl/victim_alloc_ctrl_select.sv
// victim_select: combinational victim choice.
//   valid_i       : per-way valid bits of the set
//   plru_way_i    : way proposed by the PLRU generator
//   victim_o      : lowest invalid way if any, else plru_way_i
//   any_invalid_o : at least one way is invalid
module victim_select
  import repl_pkg::*;
#(
  parameter int SET_ASSOC = 4,
  parameter int WAY_WIDTH = $clog2(SET_ASSOC)
) (
  input  logic [SET_ASSOC-1:0] valid_i,
  input  logic [WAY_WIDTH-1:0] plru_way_i,
  output logic [WAY_WIDTH-1:0] victim_o,
  output logic                 any_invalid_o
);

  logic [MAX_WAYS-1:0] valid_pad;
  inv_sel_t            sel;

  // Ways beyond SET_ASSOC are padded valid so they are never picked.
  always_comb begin
    valid_pad                  = '1;
    valid_pad[SET_ASSOC-1:0]   = valid_i;
    sel                        = first_invalid(valid_pad);
    any_invalid_o              = sel.found;
    victim_o                   = sel.found ? sel.way[WAY_WIDTH-1:0] : plru_way_i;
  end

endmodule

// File: rtl/victim_alloc_ctrl.sv
// victim_alloc_ctrl: one-at-a-time miss handler.
// Accept miss -> read set valid/dirty -> choose victim -> optional
// writeback -> refill -> PLRU update + done pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : victim_alloc_ctrl_if.master (pipeline, tag RAM, PLRU, bus)
module victim_alloc_ctrl
  import repl_pkg::*;
#(
  parameter int SET_ASSOC   = 4,
  parameter int INDEX_WIDTH = 7,
  parameter int WAY_WIDTH   = $clog2(SET_ASSOC)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  victim_alloc_ctrl_if.master  bus
);

  if (!assoc_legal(SET_ASSOC)) begin : g_bad_assoc
    $error("victim_alloc_ctrl: SET_ASSOC must be 2 or 4");
  end

  victim_state_t          state_q, state_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [SET_ASSOC-1:0]   valid_q, valid_d;
  logic [SET_ASSOC-1:0]   dirty_q, dirty_d;
  logic [WAY_WIDTH-1:0]   victim_q, victim_d;
  logic [WAY_WIDTH-1:0]   sel_way;
  logic                   sel_any_invalid;
  logic                   victim_dirty;
  logic                   idle;
  logic [MAX_WAYS-1:0]    victim_oh;

  victim_select #(
    .SET_ASSOC (SET_ASSOC),
    .WAY_WIDTH (WAY_WIDTH)
  ) u_sel (
    .valid_i       (valid_q),
    .plru_way_i    (bus.plru_repl_index),
    .victim_o      (sel_way),
    .any_invalid_o (sel_any_invalid)
  );

  // A PLRU victim is only chosen when every way is valid, so dirty alone
  // decides; an invalid victim never needs a writeback.
  assign victim_dirty = !sel_any_invalid && dirty_q[sel_way];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      valid_q  <= '0;
      dirty_q  <= '0;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      dirty_q  <= dirty_d;
      victim_q <= victim_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    dirty_d  = dirty_q;
    victim_d = victim_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.miss_req) begin
          idx_d   = bus.miss_index;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        // RAM data answers the tag_rd issued in the accept cycle.
        valid_d = bus.way_valid;
        dirty_d = bus.way_dirty;
        state_d = ST_CHOOSE;
      end
      ST_CHOOSE: begin
        victim_d = sel_way;
        state_d  = victim_dirty ? ST_WB : ST_REFILL;
      end
      ST_WB: begin
        // refill_done is deliberately not looked at here.
        if (bus.wb_ack) state_d = ST_REFILL;
      end
      ST_REFILL: begin
        if (bus.refill_done) state_d = ST_UPDATE;
      end
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign idle      = (state_q == ST_IDLE);
  assign victim_oh = onehot(MAX_WAY_W'(victim_q));

  assign bus.miss_ready   = idle;
  assign bus.tag_rd       = idle && bus.miss_req;
  // Index is live in the accept cycle, then the captured copy is held.
  assign bus.tag_rd_index = idle ? bus.miss_index : idx_q;
  assign bus.plru_index   = idle ? bus.miss_index : idx_q;

  assign bus.wb_req       = (state_q == ST_WB);
  assign bus.wb_way       = victim_q;
  assign bus.wb_index     = idx_q;

  assign bus.refill_req   = (state_q == ST_REFILL);
  assign bus.refill_way   = victim_q;
  assign bus.refill_index = idx_q;

  assign bus.plru_update  = (state_q == ST_UPDATE);
  assign bus.plru_access  = (state_q == ST_UPDATE) ? victim_oh[SET_ASSOC-1:0] : '0;
  assign bus.done         = (state_q == ST_UPDATE);
  assign bus.done_way     = victim_q;

endmodule

// File: tb/tb_victim_alloc_ctrl.sv
// Bench for victim_alloc_ctrl: directed cases plus randomized misses,
// compared cycle by cycle with a transaction timeline model.
module tb_victim_alloc_ctrl;
  localparam int SA = 4;
  localparam int IW = 7;
  localparam int WW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  victim_alloc_ctrl_if #(.SET_ASSOC(SA), .INDEX_WIDTH(IW)) bus ();

  victim_alloc_ctrl #(.SET_ASSOC(SA), .INDEX_WIDTH(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference rules: lowest invalid way wins; otherwise the PLRU proposal.
  function automatic int model_victim(input logic [3:0] v, input int plru);
    for (int i = 0; i < SA; i++) if (!v[i]) return i;
    return plru;
  endfunction

  function automatic bit model_wb(input logic [3:0] v, input logic [3:0] d, input int plru);
    return (v == 4'hF) && d[plru];
  endfunction

  task automatic drive_quiet();
    bus.miss_req        = 1'b0;
    bus.miss_index      = '0;
    bus.way_valid       = '0;
    bus.way_dirty       = '0;
    bus.plru_repl_index = '0;
    bus.wb_ack          = 1'b0;
    bus.refill_done     = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive_quiet();
      @(negedge clk);
      chk("idle_ready", bus.miss_ready, 1);
      chk("idle_done", bus.done, 0);
      chk("idle_wb_req", bus.wb_req, 0);
      chk("idle_refill_req", bus.refill_req, 0);
      @(posedge clk); #1;
    end
  endtask

  // Entered at posedge+1 with the DUT idle. Cycle 0 is the accept cycle.
  // Timeline: 1 LOOKUP, 2 CHOOSE, W writeback cycles (ack on the last),
  // R refill cycles (done on the last), then one completion cycle.
  task automatic run_miss(input logic [IW-1:0] idx, input logic [3:0] v, input logic [3:0] d,
                          input int plru, input int W, input int R, input bit noise,
                          input bit hold, input bit both, input logic [IW-1:0] nxt,
                          input int rst_at);
    int vic, wb_end, rf_end, dn;
    bit wb, in_wb, in_rf;
    vic    = model_victim(v, plru);
    wb     = model_wb(v, d, plru);
    wb_end = 2 + (wb ? W : 0);
    rf_end = wb_end + R;
    dn     = rf_end + 1;
    for (int c = 0; c <= dn; c++) begin
      in_wb = wb && (c >= 3) && (c <= wb_end);
      in_rf = (c > wb_end) && (c <= rf_end);
      if (c == 0) begin
        bus.miss_req = 1'b1; bus.miss_index = idx;
      end else if (hold) begin
        bus.miss_req = 1'b1; bus.miss_index = nxt;
      end else begin
        bus.miss_req   = noise ? 1'($urandom_range(1)) : 1'b0;
        bus.miss_index = IW'($urandom);
      end
      bus.way_valid       = (c == 1) ? v : 4'($urandom);
      bus.way_dirty       = (c == 1) ? d : 4'($urandom);
      bus.plru_repl_index = (c == 2) ? WW'(plru) : WW'($urandom);
      bus.wb_ack          = in_wb ? (c == wb_end) : (noise && $urandom_range(1) == 1);
      bus.refill_done     = in_rf ? (c == rf_end)
                          : ((both && wb && c == wb_end) || (noise && $urandom_range(1) == 1));
      @(negedge clk);
      chk("miss_ready", bus.miss_ready, c == 0);
      chk("tag_rd", bus.tag_rd, c == 0);
      if (c == 0) chk("tag_rd_index", bus.tag_rd_index, idx);
      chk("plru_index", bus.plru_index, idx);
      chk("wb_req", bus.wb_req, in_wb);
      if (in_wb) begin
        chk("wb_way", bus.wb_way, vic);
        chk("wb_index", bus.wb_index, idx);
      end
      chk("refill_req", bus.refill_req, in_rf);
      if (in_rf) begin
        chk("refill_way", bus.refill_way, vic);
        chk("refill_index", bus.refill_index, idx);
      end
      chk("done", bus.done, c == dn);
      chk("plru_update", bus.plru_update, c == dn);
      chk("plru_access", bus.plru_access, (c == dn) ? (4'b0001 << vic) : 4'b0000);
      if (c == dn) chk("done_way", bus.done_way, vic);
      if (c == rst_at) begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_refill_req", bus.refill_req, 0);
        chk("rst_wb_req", bus.wb_req, 0);
        chk("rst_miss_ready", bus.miss_ready, 1);
        chk("rst_done", bus.done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_quiet();
        bus.refill_done = 1'b1;
        @(negedge clk);
        chk("spurious_done", bus.done, 0);
        chk("spurious_ready", bus.miss_ready, 1);
        @(posedge clk); #1;
        bus.refill_done = 1'b0;
        @(negedge clk);
        chk("post_rst_done", bus.done, 0);
        chk("post_rst_refill", bus.refill_req, 0);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, got timeout required finish");
    $fatal(1);
  end

  initial begin
    logic [IW-1:0] idx, nxt;
    logic [3:0]    v, d;
    int            plru, W, R;
    bit            hold, chained;

    drive_quiet();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", bus.miss_ready, 1);
    chk("reset_tag_rd", bus.tag_rd, 0);
    chk("reset_wb_req", bus.wb_req, 0);
    chk("reset_refill_req", bus.refill_req, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_plru_update", bus.plru_update, 0);
    chk("reset_plru_access", bus.plru_access, 0);
    chk("reset_wb_way", bus.wb_way, 0);
    chk("reset_refill_way", bus.refill_way, 0);
    chk("reset_refill_index", bus.refill_index, 0);
    chk("reset_done_way", bus.done_way, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // cold miss, refill returned immediately
    run_miss(7'd5, 4'b0000, 4'b0000, 2, 1, 1, 1'b0, 1'b0, 1'b0, '0, -1);
    idle(1);
    // partial set: invalid way 2 beats PLRU even with dirty bits set
    run_miss(7'd9, 4'b1011, 4'b1111, 0, 1, 1, 1'b0, 1'b0, 1'b0, '0, -1);
    idle(1);
    // full clean set
    run_miss(7'd33, 4'b1111, 4'b0000, 3, 1, 2, 1'b0, 1'b0, 1'b0, '0, -1);
    idle(1);
    // full set, dirty victim 3, ack on 6th wb cycle with simultaneous refill_done
    run_miss(7'd64, 4'b1111, 4'b1000, 3, 6, 1, 1'b0, 1'b0, 1'b1, '0, -1);
    idle(1);
    // back-to-back with miss_req held high
    run_miss(7'd1, 4'b1111, 4'b0001, 0, 2, 1, 1'b0, 1'b1, 1'b0, 7'd2, -1);
    run_miss(7'd2, 4'b0111, 4'b0000, 1, 1, 1, 1'b0, 1'b0, 1'b0, '0, -1);
    idle(1);
    // reset while refill is pending
    run_miss(7'd77, 4'b1111, 4'b0000, 1, 1, 5, 1'b0, 1'b0, 1'b0, '0, 4);
    idle(1);

    chained = 1'b0;
    nxt     = '0;
    for (int k = 0; k < 150; k++) begin
      idx     = chained ? nxt : IW'($urandom);
      v       = ($urandom_range(2) == 0) ? 4'($urandom) : 4'hF;
      d       = 4'($urandom);
      plru    = $urandom_range(SA - 1);
      W       = $urandom_range(1, 4);
      R       = $urandom_range(1, 4);
      hold    = ($urandom_range(3) == 0);
      nxt     = IW'($urandom);
      run_miss(idx, v, d, plru, W, R, 1'b1, hold, ($urandom_range(1) == 1), nxt, -1);
      chained = hold;
      if (!hold) idle($urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/victim_alloc_ctrl.md
Name: victim_alloc_ctrl

Overview:
- Miss-handling controller sitting between the cache pipeline, the tag/valid/dirty RAM, the per-set pseudo-LRU replacement generator and the bus interface.
- On each accepted miss it reads the set's valid/dirty bits, chooses a victim way, writes the victim back if it is dirty, and refills the line.
- Once the refill completes it pulses the PLRU update for the filled way and reports completion to the pipeline.
- Handles one miss at a time, with no overlap between misses.

Parameters:
- SET_ASSOC, 4, number of ways; only 2 and 4 are legal, matching the replacement generator.
- INDEX_WIDTH, 7, set index width.
- WAY_WIDTH, $clog2(SET_ASSOC), way number width (derived).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- miss_req  in  1  miss pending; held until accepted
- miss_index  in  INDEX_WIDTH  set index of the miss
- miss_ready  out  1  controller idle; a miss is accepted when miss_req&&miss_ready
- tag_rd  out  1  one-cycle read strobe to the tag RAM
- tag_rd_index  out  INDEX_WIDTH  set to read
- way_valid  in  SET_ASSOC  valid bits; sampled exactly 1 cycle after tag_rd
- way_dirty  in  SET_ASSOC  dirty bits; same timing as way_valid
- plru_index  out  INDEX_WIDTH  set whose PLRU state is selected (held from accept to done)
- plru_repl_index  in  WAY_WIDTH  victim proposed by the PLRU generator for plru_index
- plru_access  out  SET_ASSOC  one-hot filled way
- plru_update  out  1  one-cycle PLRU state update strobe
- wb_req  out  1  writeback request; held until wb_ack
- wb_way  out  WAY_WIDTH  way to write back
- wb_index  out  INDEX_WIDTH  set to write back
- wb_ack  in  1  writeback complete (single-cycle)
- refill_req  out  1  refill request; held until refill_done
- refill_way  out  WAY_WIDTH  destination way
- refill_index  out  INDEX_WIDTH  destination set
- refill_done  in  1  line written and valid (single-cycle)
- done  out  1  one-cycle completion pulse
- done_way  out  WAY_WIDTH  filled way; valid while done=1

Behaviour:
- Reset: asynchronous, rst_n low. FSM=IDLE. All strobes and requests 0 (tag_rd, plru_update, wb_req, refill_req, done). All index/way registers 0. miss_ready=1 (it is combinational: state==IDLE).
- States: IDLE, LOOKUP, CHOOSE, WB, REFILL, UPDATE.
- IDLE: on miss_req&&miss_ready, register miss_index, assert tag_rd for 1 cycle with tag_rd_index=miss_index, then go to LOOKUP.
- LOOKUP: one wait cycle for the RAM. Register way_valid/way_dirty at the end of this cycle. Go to CHOOSE.
- CHOOSE: victim = lowest-numbered invalid way if any way is invalid; otherwise victim = plru_repl_index, sampled this cycle. Register the victim. If the victim is valid and dirty, go to WB; otherwise go to REFILL.
- WB: wb_req=1 with wb_way/wb_index stable. On wb_ack, drop wb_req the next cycle and go to REFILL.
- REFILL: refill_req=1 with refill_way/refill_index stable. On refill_done, go to UPDATE.
- UPDATE: plru_update=1, plru_access=onehot(victim), done=1, done_way=victim, all for exactly 1 cycle. Go to IDLE.
- Latency from accept cycle to done: 4 cycles for a clean or invalid victim, with no refill wait (0 bus cycles). Add the wb and refill wait cycles otherwise.
- Earliest next accept: the cycle after done.
- wb_ack or refill_done outside the matching state: ignored.
- wb_ack and refill_done in the same WB cycle: only wb_ack is honoured. The refill must still be requested.
- Invalid ways take priority over the PLRU proposal even when dirty bits are set (dirty is qualified by valid).
- plru_access=0 whenever plru_update=0.
- rst_n asserted mid-WB or mid-REFILL: requests drop immediately (asynchronous) and the FSM returns to IDLE. The bus side is reset by the same rst_n.

Decomposition:
- Shared package repl_pkg: state enum victim_state_t; SET_ASSOC legality check; function first_invalid(valid) returning {found, way}; function onehot(way).
- Sub-module: victim_select, combinational, containing the invalid-first and PLRU-fallback priority. It is reusable by a future store-miss path.
- The FSM stays in victim_alloc_ctrl.

Test Plan:
- Cold miss: set 5, way_valid=4'b0000 -> victim way 0, no wb_req, refill_way=0, done after 4 cycles with refill_done returned immediately, plru_access=4'b0001.
- Partial set: way_valid=4'b1011, plru_repl_index=0 -> victim way 2 (PLRU ignored), plru_access=4'b0100.
- Full set, clean: way_valid=4'b1111, way_dirty=4'b0000, plru_repl_index=3 -> refill_way=3, wb_req never asserted.
- Full set, dirty victim: way_dirty=4'b1000, plru_repl_index=3, wb_ack after 6 cycles -> wb_req for exactly 6 cycles with wb_way=3, then refill_req, then done with done_way=3.
- Back-to-back: miss_req held high for two misses (sets 1 then 2) -> second accept exactly one cycle after the first done; tag_rd_index=2; no overlap of requests.
- Reset mid-refill: rst_n low while refill_req=1 -> refill_req=0 and miss_ready=1 asynchronously. A spurious refill_done after reset produces no done pulse.
